dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AW, 8, data memory address width; DW, 8, data width; STARVE_MAX, 4, host wait cycles before forced grant (legal range 1..15).
REQ-002 Ports SHALL be (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- core_req  in  1  core load/store this cycle
- core_we  in  1  core store
- core_addr  in  AW  core address
- core_wdata  in  DW  core store data
- core_rdata  out  DW  combinational load data to core
- core_stall  out  1  core must hold PC and instruction this cycle
- host_req  in  1  host access pending
- host_we  in  1  host write
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access performed this cycle
- host_rdata  out  DW  registered host read data
- host_rvalid  out  1  host_rdata valid, one-cycle pulse
- mem_we  out  1  data memory write enable
- mem_addr  out  AW  data memory address
- mem_wdata  out  DW  data memory write data
- mem_rdata  in  DW  data memory asynchronous read data
- arb_state  out  2  FSM state: 0 IDLE, 1 WAIT, 2 FORCE

Function
REQ-003 Memory port SHALL be driven by exactly one owner per cycle: the host when host_gnt=1, otherwise the core; mem_we SHALL equal the owner's we gated by its req.
REQ-004 core_rdata SHALL equal mem_rdata combinationally in every cycle; it is meaningful only when the core owns the port.
REQ-005 Host handshake: host SHALL hold req/we/addr/wdata stable until it samples host_gnt=1; the transfer completes in the gnt cycle; host_req may be reasserted in the next cycle.
REQ-006 In IDLE: host_req & !core_req -> host_gnt=1 in the same cycle, stay IDLE; host_req & core_req -> core owns, next state WAIT with wait count 1.
REQ-007 In WAIT: !core_req -> host_gnt=1, next IDLE, count 0; core_req & count<STARVE_MAX -> core owns, count+1; core_req & count==STARVE_MAX -> next FORCE.
REQ-008 In FORCE: host_gnt=1, core_stall=core_req, next IDLE, count 0.
REQ-009 host_req deasserted while in WAIT (protocol violation) SHALL return the FSM to IDLE with count 0 and no grant.
REQ-010 For a granted host read, host_rdata SHALL capture mem_rdata at the end of the gnt cycle and host_rvalid SHALL pulse high for exactly the following cycle; host writes produce no rvalid.
REQ-011 core_stall SHALL be 0 in IDLE and WAIT; a stalled core access SHALL be re-presented by the core and served in the next cycle.
REQ-012 Wait count SHALL be 4 bits and never exceed STARVE_MAX.

Reset
REQ-013 While reset=0 (asynchronously): state IDLE, wait count 0, host_rdata 0, host_rvalid 0; host_gnt and core_stall SHALL be 0 regardless of inputs.
REQ-014 Reset asserted mid-WAIT or mid-FORCE SHALL abort the pending host access with no grant; the host re-requests after release.

Configuration
REQ-015 Macro DMEM_ARB_STARVE_GUARD_EN defined: behaviour per REQ-006..REQ-012.
REQ-016 Macro undefined: no FORCE state; core has absolute priority; WAIT holds until !core_req; count still increments and saturates at STARVE_MAX; core_stall tied 0; arb_state never reads 2.

Structure
REQ-017 Package dmem_arb_pkg SHALL hold the arb_state enum (IDLE/WAIT/FORCE, 2-bit) and the default AW/DW/STARVE_MAX constants.
REQ-018 Implementation SHALL be a single flat module; no sub-module.

Verification (STARVE_MAX=4, guard enabled unless noted)
REQ-019 Host write addr 0x10 data 0xA5 with core_req=0 -> host_gnt=1 same cycle, mem_we=1, mem_addr=0x10; subsequent host read of 0x10 -> host_rvalid next cycle with host_rdata=0xA5.
REQ-020 core_req held 1 and host_req asserted at cycle 0 -> arb_state WAIT for cycles 1..4, FORCE at cycle 5 with host_gnt=1 and core_stall=1, IDLE at cycle 6.
REQ-021 Same stimulus with macro undefined -> host_gnt stays 0 and core_stall stays 0 until core_req drops, then host_gnt=1 that cycle.
REQ-022 Core store 0x3C to 0x20 and host read of 0x20 both requested at cycle 0 -> core write at cycle 0; host served when core idles, returning host_rdata=0x3C.
REQ-023 reset pulled low during FORCE -> host_gnt, core_stall and host_rvalid drop immediately; after release arb_state=IDLE with no spurious grant.
REQ-024 host_req dropped while in WAIT -> next state IDLE, no host_gnt, no host_rvalid.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: the arbitration state
//   encoding (visible on the arb_state port) and the default geometry and
//   starvation limit used as parameter defaults by dmem_arbiter.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    // Arbitration state; the encoding is exported on arb_state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    localparam int DMEM_AW         = 8;   // data memory address width
    localparam int DMEM_DW         = 8;   // data width
    localparam int DMEM_STARVE_MAX = 4;   // host wait cycles before forced grant
    localparam int WAIT_CNT_W      = 4;   // wait counter width

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between a CPU core and an external host.
//   The core normally owns the port; a host request is served in any cycle the
//   core is idle. A host kept waiting behind a busy core is counted, and with
//   the starvation guard built in it is forcibly granted after STARVE_MAX
//   waiting cycles, stalling the core for that one cycle.
//
//   Build option:
//     DMEM_ARB_STARVE_GUARD_EN  defined   -> FORCE state present, core may stall
//                               undefined -> core has absolute priority,
//                                            core_stall tied low
//
//   Ports:
//     clk, reset                 clock, asynchronous active-low reset
//     core_req/we/addr/wdata     core load/store request
//     core_rdata, core_stall     load data (combinational), stall to core
//     host_req/we/addr/wdata     host request, held until host_gnt
//     host_gnt                   host access performed this cycle
//     host_rdata, host_rvalid    registered host read data + one-cycle valid
//     mem_we/addr/wdata, mem_rdata  data memory port (async read)
//     arb_state                  current arbitration state (0 IDLE/1 WAIT/2 FORCE)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = DMEM_AW,
    parameter int DW         = DMEM_DW,
    parameter int STARVE_MAX = DMEM_STARVE_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    arb_state
);

    localparam logic [WAIT_CNT_W-1:0] STARVE_LIM = WAIT_CNT_W'(STARVE_MAX);

    arb_state_e            state_q,       state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic [DW-1:0]         host_rdata_q,  host_rdata_d;
    logic                  host_rvalid_q, host_rvalid_d;

    logic gnt_raw;
    logic stall_raw;

    // -------------------------------------------------------------------------
    // Next-state and grant decision
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default before the case so no path leaves it
    //       unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        gnt_raw    = 1'b0;
        stall_raw  = 1'b0;

        unique case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (host_req) begin
                    if (core_req) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_CNT_W'(1);
                    end else begin
                        gnt_raw = 1'b1;
                    end
                end
            end

            WAIT: begin
                if (!host_req) begin
                    // Host withdrew its request: abandon it without a grant.
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (!core_req) begin
                    gnt_raw    = 1'b1;
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < STARVE_LIM) begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end else begin
`ifdef DMEM_ARB_STARVE_GUARD_EN
                    state_d = FORCE;
`else
                    // No guard: keep waiting, counter saturated.
                    wait_cnt_d = STARVE_LIM;
`endif
                end
            end

`ifdef DMEM_ARB_STARVE_GUARD_EN
            FORCE: begin
                // Host takes the port; a requesting core must replay next cycle.
                gnt_raw    = 1'b1;
                stall_raw  = core_req;
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
`endif

            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Grant and stall must read low the instant reset is asserted, not just
    // after the state register clears.
    assign host_gnt   = gnt_raw & reset;
    assign core_stall = stall_raw & reset;

    // -------------------------------------------------------------------------
    // Memory port ownership
    // -------------------------------------------------------------------------
    assign mem_we     = host_gnt ? (host_we & host_req) : (core_we & core_req);
    assign mem_addr   = host_gnt ? host_addr  : core_addr;
    assign mem_wdata  = host_gnt ? host_wdata : core_wdata;
    assign core_rdata = mem_rdata;

    // -------------------------------------------------------------------------
    // Host read return path
    // -------------------------------------------------------------------------
    always_comb begin
        host_rvalid_d = host_gnt & ~host_we;
        host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    //       the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign arb_state   = state_q;

endmodule : dmem_arbiter
